// File: rtl/odd_parity_tx.sv
// rtl/odd_parity_tx.sv - serial framer: start bit, 4 data bits LSB first, parity bit, stop bit(s)
//
// Purpose:
//   Accepts a nibble plus its upstream-generated odd-parity bit over a
//   valid/ready handshake and shifts one frame out on a single serial line.
//   Frame: start(0), d0, d1, d2, d3, parity, stop(1) [, second stop(1)].
//   Each bit lasts CLKS_PER_BIT clock cycles. The parity bit is sent exactly
//   as supplied; it is not checked here.
//
// Configuration macro:
//   ODD_PARITY_TX_TWO_STOP_EN - when defined, a second stop bit (STOP2)
//   follows STOP, making the frame 8 bit periods long instead of 7.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit, legal range 2..255
//
// Ports:
//   clk    in  1  clock, all state updates on the rising edge
//   rst_n  in  1  synchronous active-low reset
//   data   in  4  nibble to send, sampled on acceptance
//   parity in  1  parity bit to send, sampled with data
//   valid  in  1  producer offers data/parity
//   ready  out 1  framer can accept (combinational, state == IDLE)
//   tx     out 1  serial line, registered, idles high
//   busy   out 1  registered, high from acceptance until the frame ends

module odd_parity_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data,
    input  logic       parity,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
`ifdef ODD_PARITY_TX_TWO_STOP_EN
        STOP  = 3'd4,
        STOP2 = 3'd5
`else
        STOP  = 3'd4
`endif
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       idx, idx_n;
    // {parity, d3, d2, d1, d0}; shifted right at each bit boundary so that
    // bit 0 always holds the next bit to drive, and after the four data
    // shifts the parity bit has moved down into bit 0.
    logic [4:0]       sh, sh_n;
    logic             tx_q, tx_n;
    logic             busy_q, busy_n;
    logic             last;

    assign ready = (state == IDLE);
    assign tx    = tx_q;
    assign busy  = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            sh     <= '0;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            sh     <= sh_n;
            tx_q   <= tx_n;
            busy_q <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        sh_n    = sh;
        tx_n    = tx_q;
        busy_n  = busy_q;
        last    = (cnt == CNT_MAX);
        // The bit timer restarts on every state change and is held at 0 in IDLE.
        cnt_n   = (state == IDLE || last) ? '0 : cnt + 1'b1;

        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                idx_n  = '0;
                if (valid) begin
                    sh_n    = {parity, data};
                    state_n = START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (last) begin
                    tx_n    = sh[0];
                    sh_n    = {1'b0, sh[4:1]};
                    idx_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (last) begin
                    // After d3 the shifted register presents the parity bit.
                    tx_n = sh[0];
                    sh_n = {1'b0, sh[4:1]};
                    if (idx == 2'd3) begin
                        state_n = PAR;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            PAR: begin
                if (last) begin
                    tx_n    = 1'b1;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (last) begin
`ifdef ODD_PARITY_TX_TWO_STOP_EN
                    state_n = STOP2;
`else
                    state_n = IDLE;
                    busy_n  = 1'b0;
`endif
                end
            end
`ifdef ODD_PARITY_TX_TWO_STOP_EN
            STOP2: begin
                if (last) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                idx_n   = '0;
            end
        endcase
    end

endmodule

// File: doc/odd_parity_tx.md
# odd_parity_tx

Serial framer that consumes a 4-bit data nibble together with the odd-parity bit produced by the upstream `odd_parity` stage. It emits one asynchronous-style frame per accepted nibble on a single line: start bit, data LSB first, parity bit, stop bit. A valid/ready handshake on the input side lets the producer stall while a frame is in flight. It sits directly downstream of the parity generator and drives the serial link.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 2..255.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `data`  in  4  nibble to send; sampled on acceptance.
- `parity`  in  1  odd-parity bit from the upstream stage; sampled with `data`, transmitted unmodified.
- `valid`  in  1  producer has a nibble and parity bit to send.
- `ready`  out  1  framer can accept; combinational, equal to (state == IDLE).
- `tx`  out  1  serial line, registered; idle level 1.
- `busy`  out  1  registered; 1 from the acceptance edge until the frame's last bit period ends.

## Operation
- States: IDLE, START, DATA, PAR, STOP (plus STOP2 when the configuration macro is defined).
- IDLE: `tx`=1, `busy`=0. On an edge where `valid` && `ready`: latch `data`/`parity` into a shift register, go to START, `tx`<=0, `busy`<=1, clear the bit counter.
- Every state other than IDLE lasts exactly `CLKS_PER_BIT` cycles, timed by a counter 0..`CLKS_PER_BIT`-1 that wraps to 0 on each state change.
- START -> DATA: `tx`<=d0.
- DATA: `tx` shows d0, d1, d2, d3 in order. A 2-bit index advances at each bit boundary. After d3, go to PAR.
- PAR: `tx`<=latched parity. Then STOP: `tx`<=1.
- At the end of STOP, go to IDLE and set `busy`<=0.
- `data`/`parity` changes after acceptance do not affect the frame in flight.
- `valid` is ignored outside IDLE. There is no buffering: a producer must hold `valid` until it sees `ready`.
- The block does not check that the parity is correct; a wrong parity bit is sent as given.
- Reset (`rst_n`=0 at an edge) applies in any state, including mid-frame: go to IDLE, `tx`=1, `busy`=0, counters 0, shift register 0. The aborted frame is discarded. `valid` is ignored on that edge.

## Timing
- Reset values: `tx`=1, `busy`=0, `ready`=1.
- Latency: `tx` falls in the cycle immediately after the accepting edge.
- Frame length: 7×`CLKS_PER_BIT` cycles (8× with the macro defined).
- Back-to-back: `ready` reasserts the cycle after the stop period ends, so the earliest next acceptance is that cycle's edge. There is exactly one idle cycle (`tx`=1) between frames when `valid` is held high.
- The acceptance edge and the first START cycle count as START cycle 0. Bit k occupies cycles [1+k·C, 1+(k+1)·C) after the accepting edge, where C=`CLKS_PER_BIT`.
- The counter needs a width that holds `CLKS_PER_BIT`-1. The bit index never exceeds 3.

## Configuration
- `ODD_PARITY_TX_TWO_STOP_EN` defined: a STOP2 state follows STOP. It lasts one more `CLKS_PER_BIT` period with `tx`=1, so the frame is 8 bit-periods and `busy`/`ready` timing shifts by C cycles.
- Not defined: a single stop bit, 7-bit-period frame. STOP2 logic is not compiled.

## Test plan
- C=4, reset held 3 cycles, then released with `valid`=0 -> `tx`=1, `busy`=0, `ready`=1 on every cycle.
- C=4, accept `data`=0001, `parity`=0 -> `tx` bit sequence 0,1,0,0,0,0,1, each held exactly 4 cycles. `busy` high for 28 cycles. `ready` is back at cycle 29.
- C=4, `valid` held high with 0000/1 then 1111/1 -> two frames (0,0,0,0,0,1,1 then 0,1,1,1,1,1,1) separated by exactly one idle cycle. Changing `data` mid-frame does not alter the output.
- C=4, accept 0111/0, assert `rst_n`=0 during the d2 bit -> next cycle `tx`=1, `busy`=0, `ready`=1. The next accepted 0010/0 produces a clean full frame.
- C=4, `ODD_PARITY_TX_TWO_STOP_EN` defined, accept 0001/0 -> stop level held 8 cycles and the frame lasts 32 cycles. Without the macro the same stimulus gives 28 cycles.
- C=2, `parity` deliberately wrong (0001/1) -> the parity slot shows 1. Timing is unchanged with the minimum bit width.
